// File: rtl/rom_pkg.sv
// Shared types and constants for the instruction ROM loader.
// ROM_CHECKSUM_EN adds the CHECK state used to verify a trailing checksum byte.
package rom_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
`ifdef ROM_CHECKSUM_EN
        , ST_CHECK
`endif
    } rom_state_t;

endpackage

// File: rtl/instr_rom_loader_if.sv
// Host load stream plus CPU fetch port of the instruction ROM loader.
// master = host/CPU side, slave = loader.
interface instr_rom_loader_if
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W
);

    logic              load_start;
    logic [ADDR_W-1:0] load_len;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_ready;
    logic              load_done;
    logic              cpu_reset;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        opcode1;
    logic [7:0]        opcode2;
    logic              fetch_err;
    logic              csum_err;

    modport master (
        output load_start, load_len, load_valid, load_data, rom_address,
        input  load_ready, load_done, cpu_reset, opcode1, opcode2, fetch_err, csum_err
    );

    modport slave (
        input  load_start, load_len, load_valid, load_data, rom_address,
        output load_ready, load_done, cpu_reset, opcode1, opcode2, fetch_err, csum_err
    );

endinterface

// File: rtl/rom_store.sv
// 2**ADDR_W x 8 program array: one write port, two registered read ports
// at addr and addr+1 (wrapping). Reads return NOP_OPCODE when not enabled.
module rom_store
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data0,
    output logic [7:0]        rd_data1
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr1;
    logic [7:0]        rd_data0_d, rd_data0_q;
    logic [7:0]        rd_data1_d, rd_data1_q;

    // Array contents survive reset on purpose; only the read registers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_addr1   = rd_addr + ADDR_W'(1);
        rd_data0_d = NOP_OPCODE;
        rd_data1_d = NOP_OPCODE;
        if (rd_en) begin
            rd_data0_d = mem[rd_addr];
            rd_data1_d = mem[rd_addr1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data0_q <= NOP_OPCODE;
            rd_data1_q <= NOP_OPCODE;
        end else begin
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
        end
    end

    assign rd_data0 = rd_data0_q;
    assign rd_data1 = rd_data1_q;

endmodule

// File: rtl/instr_rom_loader.sv
// Loads a byte-serial program image and serves two-byte CPU fetches from it.
// Define ROM_CHECKSUM_EN to require a trailing byte making the 8-bit sum zero.
module instr_rom_loader
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    instr_rom_loader_if.slave   bus
);

    localparam int CNT_W = ADDR_W + 1;

    rom_state_t       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [ADDR_W-1:0] len_d, len_q;
    logic             done_d, done_q;
    logic             fetch_err_d, fetch_err_q;
    logic [CNT_W-1:0] len_full;
    logic             ready;
    logic             hs;
    logic             wr_en;
    logic             rd_en;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]       sum_d, sum_q;
    logic             csum_err_d, csum_err_q;
`endif

    // A stored length of zero means the full array.
    assign len_full = {(len_q == '0), len_q};

    always_comb begin
        ready = (state_q == ST_LOAD);
`ifdef ROM_CHECKSUM_EN
        ready = ready | (state_q == ST_CHECK);
`endif
        hs = bus.load_valid & ready;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
`ifdef ROM_CHECKSUM_EN
        sum_d      = sum_q;
        csum_err_d = csum_err_q;
`endif
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    len_d   = bus.load_len;
`ifdef ROM_CHECKSUM_EN
                    sum_d      = 8'h00;
                    csum_err_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef ROM_CHECKSUM_EN
                    sum_d = sum_q + bus.load_data;
                    if (cnt_d == len_full) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (cnt_d == len_full) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef ROM_CHECKSUM_EN
            ST_CHECK: begin
                if (hs) begin
                    sum_d = sum_q + bus.load_data;
                    if (sum_d == 8'h00) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        csum_err_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch outputs are only live for cycles fully inside RUN, so the first
    // RUN cycle (load_done) and the first LOAD cycle after a restart read as NOP.
    always_comb begin
        wr_en       = hs & (state_q == ST_LOAD);
        rd_en       = (state_q == ST_RUN) & (state_d == ST_RUN);
        fetch_err_d = 1'b0;
        if (rd_en) begin
            fetch_err_d = bus.rom_address[0] |
                          (({1'b0, bus.rom_address} + CNT_W'(1)) >= len_full);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            fetch_err_q <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            sum_q      <= 8'h00;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            done_q      <= done_d;
            fetch_err_q <= fetch_err_d;
`ifdef ROM_CHECKSUM_EN
            sum_q      <= sum_d;
            csum_err_q <= csum_err_d;
`endif
        end
    end

    rom_store #(
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (cnt_q[ADDR_W-1:0]),
        .wr_data  (bus.load_data),
        .rd_en    (rd_en),
        .rd_addr  (bus.rom_address),
        .rd_data0 (bus.opcode1),
        .rd_data1 (bus.opcode2)
    );

    assign bus.load_ready = ready;
    assign bus.load_done  = done_q;
    assign bus.cpu_reset  = (state_q != ST_RUN);
    assign bus.fetch_err  = fetch_err_q;
`ifdef ROM_CHECKSUM_EN
    assign bus.csum_err   = csum_err_q;
`else
    assign bus.csum_err   = 1'b0;
`endif

endmodule
